// File: rtl/rtport_tx.sv
// Transmit end of the RTPort req/ack link: valid/ready FIFO feeding a four-phase req/ack sender.
// Optional macro RTPORT_TX_ACK_SYNC_EN adds a 2-flop synchronizer on tx_ack for cross-clock neighbours.
module rtport_tx #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     tx_req,
    input  logic                     tx_ack,
    output logic [WIDTH-1:0]         tx_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic               tx_req_q, tx_req_d;
    logic [WIDTH-1:0]   tx_data_q, tx_data_d;
    logic               push, pop;
    logic               ack_s;

`ifdef RTPORT_TX_ACK_SYNC_EN
    logic ack_meta_q, ack_sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
        end else begin
            ack_meta_q <= tx_ack;
            ack_sync_q <= ack_meta_q;
        end
    end

    assign ack_s = ack_sync_q;
`else
    assign ack_s = tx_ack;
`endif

    // No bypass: a full FIFO refuses a push even when the FSM pops in the same cycle.
    assign in_ready = rst_n && (count_q != CW'(DEPTH));
    assign push     = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        tx_req_d  = tx_req_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0 && !ack_s) begin
                    tx_data_d = mem_q[rd_ptr_q];
                    pop       = 1'b1;
                    tx_req_d  = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    tx_req_d = 1'b0;
                    state_d  = RELEASE;
                end
            end
            RELEASE: begin
                if (!ack_s) begin
                    if (count_q != '0) begin
                        tx_data_d = mem_q[rd_ptr_q];
                        pop       = 1'b1;
                        tx_req_d  = 1'b1;
                        state_d   = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                tx_req_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Pointers are AW bits wide, so natural overflow gives the modulo-DEPTH wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tx_req_q  <= 1'b0;
            tx_data_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            tx_req_q  <= tx_req_d;
            tx_data_q <= tx_data_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign tx_req  = tx_req_q;
    assign tx_data = tx_data_q;
    assign count   = count_q;
    assign busy    = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_rtport_tx.sv
// Scoreboard bench for rtport_tx: accepted flits are queued, a monitor checks every launch in order.
module tb_rtport_tx;
    localparam int W  = 512;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;
`ifdef RTPORT_TX_ACK_SYNC_EN
    localparam int ALAT = 2;
`else
    localparam int ALAT = 0;
`endif

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          tx_req;
    logic          tx_ack;
    logic [W-1:0]  tx_data;
    logic [CW-1:0] count;
    logic          busy;

    logic          man_ack, resp_ack, resp_en;
    int            resp_max, rcnt, rdly;
    logic [W-1:0]  exp_q [$];
    int            n_acc, n_launch, n_total, n_pass, base;
    logic          prev_req;
    logic [W-1:0]  held;

    rtport_tx #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .tx_req   (tx_req),
        .tx_ack   (tx_ack),
        .tx_data  (tx_data),
        .count    (count),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign tx_ack = resp_en ? resp_ack : man_ack;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // Reference model: every flit accepted at a clock edge must come out once, in order.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            n_acc = 0;
        end else if (in_valid && in_ready) begin
            exp_q.push_back(in_data);
            n_acc++;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req = 1'b0;
            n_launch = 0;
        end else begin
            if (tx_req && !prev_req) begin
                if (exp_q.size() == 0) chk("unexpected_launch", W'(1), W'(0));
                else chk("flit_order", tx_data, exp_q.pop_front());
                held = tx_data;
                n_launch++;
            end else if (tx_req) begin
                chk("data_stable", tx_data, held);
            end
            chk("count_model", W'(count), W'(n_acc - n_launch));
            prev_req = tx_req;
        end
    end

    // Auto responder: follows tx_req with a random 0..resp_max cycle delay each phase.
    always @(negedge clk) begin
        if (!resp_en || !rst_n) begin
            resp_ack = 1'b0;
            rcnt     = 0;
        end else if (tx_req != resp_ack) begin
            if (rcnt >= rdly) begin
                resp_ack = tx_req;
                rcnt     = 0;
                rdly     = $urandom_range(resp_max, 0);
            end else begin
                rcnt++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [W-1:0] d);
        logic ok;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 2000; t++) begin
            ok = in_ready;
            @(negedge clk);
            if (ok) return;
        end
        chk("push_timeout", W'(0), W'(1));
    endtask

    task automatic drain();
        for (int t = 0; t < 2000; t++) begin
            if (exp_q.size() == 0 && !busy) break;
            cyc(1);
        end
        chk("drain_done", W'(exp_q.size() == 0 && !busy), W'(1));
    endtask

    function automatic logic [W-1:0] rnd_flit();
        logic [W-1:0] f;
        for (int i = 0; i < W / 32; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        man_ack = 1'b0; resp_en = 1'b0; resp_max = 0; rdly = 0;
        n_total = 0; n_pass = 0;
        cyc(3);
        chk("rst_tx_req", W'(tx_req), W'(0));
        chk("rst_tx_data", tx_data, W'(0));
        chk("rst_count", W'(count), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(0));
        rst_n = 1'b1;
        cyc(1);
        chk("post_rst_in_ready", W'(in_ready), W'(1));

        // Single flit
        push(W'(8'hA5)); in_valid = 1'b0;
        chk("single_count", W'(count), W'(1));
        chk("single_req_lat", W'(tx_req), W'(0));
        cyc(1);
        chk("single_req", W'(tx_req), W'(1));
        chk("single_data", tx_data, W'(8'hA5));
        man_ack = 1'b1;
        cyc(ALAT);
`ifdef RTPORT_TX_ACK_SYNC_EN
        chk("sync_req_hold", W'(tx_req), W'(1));
`endif
        cyc(1);
        chk("single_req_fall", W'(tx_req), W'(0));
        chk("single_busy_rel", W'(busy), W'(1));
        man_ack = 1'b0;
        cyc(1 + ALAT);
        chk("single_idle_busy", W'(busy), W'(0));

        // Fill past DEPTH with ack held low
        for (int i = 1; i <= 5; i++) push(W'(i));
        chk("fill_req", W'(tx_req), W'(1));
        chk("fill_data", tx_data, W'(1));
        chk("fill_count", W'(count), W'(4));
        chk("fill_in_ready", W'(in_ready), W'(0));
        in_data = W'(6);
        cyc(2);
        chk("fill_stall_count", W'(count), W'(4));
        man_ack = 1'b1;
        cyc(1 + ALAT);
        chk("fill_req_fall", W'(tx_req), W'(0));
        chk("fill_no_bypass", W'(count), W'(4));
        man_ack = 1'b0;
        cyc(1 + ALAT);
        chk("fill_next_req", W'(tx_req), W'(1));
        chk("fill_next_data", tx_data, W'(2));
        chk("fill_pop_count", W'(count), W'(3));
        chk("fill_ready_again", W'(in_ready), W'(1));
        cyc(1);
        in_valid = 1'b0;
        chk("fill_sixth_in", W'(count), W'(4));
        resp_en = 1'b1;
        drain();

        // Back-to-back stream with a prompt responder
        base = n_launch;
        for (int i = 0; i < 16; i++) push(W'(i));
        in_valid = 1'b0;
        drain();
        chk("b2b_delivered", W'(n_launch - base), W'(16));

        // Random flits, random gaps, random responder latency
        resp_max = 3;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(3, 0) == 0) begin
                in_valid = 1'b0;
                cyc($urandom_range(3, 1));
            end
            push(rnd_flit());
        end
        in_valid = 1'b0;
        drain();

        // Stale ack held high across reset
        resp_en = 1'b0; man_ack = 1'b1;
        rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(3);
        push(W'(8'h3C)); in_valid = 1'b0;
        cyc(3);
        chk("stale_blocked", W'(tx_req), W'(0));
        man_ack = 1'b0;
        cyc(ALAT);
        chk("stale_wait", W'(tx_req), W'(0));
        cyc(1);
        chk("stale_launch", W'(tx_req), W'(1));
        chk("stale_data", tx_data, W'(8'h3C));
        man_ack = 1'b1; cyc(1 + ALAT);
        man_ack = 1'b0; cyc(1 + ALAT);
        chk("stale_done_busy", W'(busy), W'(0));

        // Reset in the middle of a handshake
        push(W'(8'h11)); push(W'(8'h22)); push(W'(8'h33)); in_valid = 1'b0;
        chk("midrst_count", W'(count), W'(2));
        chk("midrst_req", W'(tx_req), W'(1));
        rst_n = 1'b0;
        cyc(1);
        chk("midrst_tx_req", W'(tx_req), W'(0));
        chk("midrst_tx_data", tx_data, W'(0));
        chk("midrst_count0", W'(count), W'(0));
        chk("midrst_in_ready", W'(in_ready), W'(0));
        rst_n = 1'b1;
        cyc(1);
        push(W'(8'h77)); in_valid = 1'b0;
        resp_en = 1'b1; resp_max = 0;
        drain();
        chk("midrst_delivered", W'(n_launch), W'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual running required finished");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1);
    end

endmodule
